// File: rtl/vsa_param_core.sv
// Parametrised multi-cycle VSA core: IF/ID/EX/MEM/WB with fetch and data wait states.
// Optional HALT instruction is enabled by defining VSA_HALT_EN.
module vsa_param_core #(
  parameter  int DW   = 5,
  parameter  int PCW  = 5,
  parameter  int RW   = 2,
  localparam int IW   = 6 + 3*RW,
  localparam int IMMW = 3 + RW
) (
  input  logic           clock,
  input  logic           reset,
  output logic [PCW-1:0] pc,
  output logic           inst_req,
  input  logic [IW-1:0]  instruction,
  input  logic           inst_valid,
  output logic [DW-1:0]  alu_out,
  input  logic [DW-1:0]  datain,
  output logic [DW-1:0]  dataout,
  output logic           rd,
  output logic           wr,
  input  logic           mem_ready,
  output logic [2:0]     state,
  output logic           halted
);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  // R-format layout; I-format reuses src2 as dst and {dst,fun} as the immediate
  typedef struct packed {
    logic [2:0]    op;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;
    logic [RW-1:0] dst;
    logic [2:0]    fun;
  } inst_t;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_BEQZ = 3'd2;
  localparam logic [2:0] OP_ALU  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SUBI = 3'd5;
`ifdef VSA_HALT_EN
  localparam logic [2:0] OP_HALT = 3'd7;
`endif

  state_t          st;
  inst_t           ir;
  logic [PCW-1:0]  npc;
  logic [DW-1:0]   a, b, lmd;
  logic            cond;
  logic [DW-1:0]   rf [2**RW];

  logic [IMMW-1:0] imm;
  logic [DW-1:0]   immx, fres, exres, wdata;
  logic [PCW-1:0]  btgt;
  logic [RW-1:0]   waddr;
  logic            wen, is_mem;

  assign imm    = {ir.dst, ir.fun};
  assign immx   = DW'($signed(imm));
  assign btgt   = npc + (PCW'($signed(imm)) << 1);
  assign is_mem = (ir.op == OP_LW) || (ir.op == OP_SW);

  assign state    = st;
  assign inst_req = (st == S_IF);
  assign rd       = (st == S_MEM) && (ir.op == OP_LW);
  assign wr       = (st == S_MEM) && (ir.op == OP_SW);
  assign dataout  = b;
`ifdef VSA_HALT_EN
  assign halted   = (st == S_HALT);
`else
  assign halted   = 1'b0;
`endif

  always_comb begin
    case (ir.fun)
      3'd0: fres = a + b;
      3'd1: fres = a - b;
      3'd2: fres = a & b;
      3'd3: fres = a | b;
      3'd4: fres = a ^ b;
      3'd5: fres = ~a;
      3'd6: fres = {1'b0, a[DW-1:1]};
      3'd7: fres = {a[DW-1], a[DW-1:1]};
    endcase
  end

  always_comb begin
    exres = alu_out;
    case (ir.op)
      OP_LW, OP_SW, OP_ADDI: exres = a + immx;
      OP_SUBI:               exres = a - immx;
      OP_ALU:                exres = fres;
      OP_BEQZ:               exres = DW'(btgt);
      default:               exres = alu_out;
    endcase
  end

  always_comb begin
    wen   = 1'b0;
    waddr = ir.dst;
    wdata = alu_out;
    case (ir.op)
      OP_ALU:           wen = 1'b1;
      OP_ADDI, OP_SUBI: begin wen = 1'b1; waddr = ir.src2; end
      OP_LW:            begin wen = 1'b1; waddr = ir.src2; wdata = lmd; end
      default:          wen = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= S_IF;
      pc      <= '0;
      npc     <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      cond    <= 1'b0;
      lmd     <= '0;
      for (int i = 0; i < 2**RW; i++) rf[i] <= '0;
    end else begin
      case (st)
        S_IF: if (inst_valid) begin
          ir  <= instruction;
          npc <= pc + PCW'(2);
          st  <= S_ID;
        end
        S_ID: begin
          a  <= (ir.src1 == '0) ? '0 : rf[ir.src1];
          b  <= (ir.src2 == '0) ? '0 : rf[ir.src2];
          st <= S_EX;
        end
        S_EX: begin
          alu_out <= exres;
          if (ir.op == OP_BEQZ) cond <= (a == '0);
`ifdef VSA_HALT_EN
          st <= (ir.op == OP_HALT) ? S_HALT : S_MEM;
`else
          st <= S_MEM;
`endif
        end
        S_MEM: if (!is_mem || mem_ready) begin
          if (ir.op == OP_LW) lmd <= datain;
          pc <= (ir.op == OP_BEQZ && cond) ? PCW'(alu_out) : npc;
          st <= S_WB;
        end
        S_WB: begin
          // register 0 is hardwired, so its writes are simply dropped
          if (wen && waddr != '0) rf[waddr] <= wdata;
          st <= S_IF;
        end
        default: st <= st;
      endcase
    end
  end

endmodule

// File: tb/tb_vsa_param_core.sv
// Directed bench for vsa_param_core (default parameters); expected values hand-derived.
// Covers the HALT path too when compiled with VSA_HALT_EN.
module tb_vsa_param_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  pc;
  logic        inst_req;
  logic [11:0] instruction;
  logic        inst_valid;
  logic [4:0]  alu_out;
  logic [4:0]  datain;
  logic [4:0]  dataout;
  logic        rd, wr;
  logic        mem_ready;
  logic [2:0]  state;
  logic        halted;

  int nvec = 0;
  int nerr = 0;
  int wr_n, rd_n, cyc;
  logic [4:0] st_alu, st_dout;

  logic [11:0] alu_ir  [8] = '{12'h6F0, 12'h6F1, 12'h6F2, 12'h6F3, 12'h6F4, 12'h795, 12'h696, 12'h697};
  logic [4:0]  alu_exp [8] = '{5'd9, 5'd21, 5'd10, 5'd31, 5'd21, 5'd21, 5'd15, 5'd31};

  vsa_param_core dut (
    .clock(clock), .reset(reset), .pc(pc), .inst_req(inst_req),
    .instruction(instruction), .inst_valid(inst_valid), .alu_out(alu_out),
    .datain(datain), .dataout(dataout), .rd(rd), .wr(wr),
    .mem_ready(mem_ready), .state(state), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one instruction from IF (entered at a negedge) until back in IF or HALT.
  task automatic run(input logic [11:0] ir, input int ifw, input int memw,
                     input logic [4:0] dval, output int ncyc);
    int iw, mw;
    bit left;
    iw = ifw; mw = memw; ncyc = 0; left = 0; wr_n = 0; rd_n = 0;
    instruction = ir;
    while (!(left && (state == 3'd0 || state == 3'd5)) && ncyc < 40) begin
      inst_valid = (iw == 0);
      mem_ready  = (mw == 0);
      datain     = (mw == 0) ? dval : ~dval;
      if (wr) begin wr_n++; st_alu = alu_out; st_dout = dataout; end
      if (rd) rd_n++;
      if (state == 3'd0 && iw > 0) iw--;
      if (state == 3'd3 && mw > 0) mw--;
      @(posedge clock);
      ncyc++;
      @(negedge clock);
      if (state != 3'd0) left = 1;
    end
    if (ncyc >= 40) chk("run_timeout", ncyc, 0);
    inst_valid = 1'b1;
    mem_ready  = 1'b1;
  endtask

  initial begin
    int k;
    reset = 1'b1; instruction = '0; inst_valid = 1'b0; mem_ready = 1'b1; datain = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst_req", inst_req, 1);
    chk("rst_rdwr", {rd, wr}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_alu_out", alu_out, 0);

    // basic ALU sequence
    run(12'h825, 0, 0, 5'd0, cyc);
    chk("addi_cyc", cyc, 5); chk("addi_alu", alu_out, 5); chk("addi_pc", pc, 2);
    run(12'h6B8, 0, 0, 5'd0, cyc);
    chk("add_cyc", cyc, 5); chk("add_alu", alu_out, 10); chk("add_pc", pc, 4);

    // store with three MEM wait cycles
    run(12'h263, 0, 3, 5'd0, cyc);
    chk("sw_cyc", cyc, 8); chk("sw_wr_n", wr_n, 4);
    chk("sw_addr", st_alu, 3); chk("sw_data", st_dout, 10); chk("sw_pc", pc, 6);

    // taken branch, SUBI wrap, store R1
    run(12'h403, 0, 0, 5'd0, cyc);
    chk("beqz_alu", alu_out, 14); chk("beqz_pc", pc, 14);
    run(12'hA21, 0, 0, 5'd0, cyc);
    chk("subi_alu", alu_out, 31); chk("subi_pc", pc, 16);
    run(12'h223, 0, 0, 5'd0, cyc);
    chk("sw_r1_data", st_dout, 31); chk("sw_r1_pc", pc, 18);

    // not-taken branch, then taken branch with pc wrap
    run(12'h483, 0, 0, 5'd0, cyc);
    chk("bnt_alu", alu_out, 26); chk("bnt_pc", pc, 20);
    run(12'h407, 0, 0, 5'd0, cyc);
    chk("bwrap_alu", alu_out, 4); chk("bwrap_pc", pc, 4);

    // ALU functions with R1 = 31, R3 = 10
    for (int i = 0; i < 8; i++) begin
      run(alu_ir[i], 0, 0, 5'd0, cyc);
      chk($sformatf("alu_fun%0d", i), alu_out, alu_exp[i]);
    end
    chk("alu_pc", pc, 20);

    // fetch wait: state, pc and inst_req hold
    instruction = 12'h004; inst_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("ifw_state", state, 0); chk("ifw_pc", pc, 20); chk("ifw_inst_req", inst_req, 1);

    // load into R0 is dropped; load into R2 lands
    run(12'h004, 0, 2, 5'h13, cyc);
    chk("lw0_cyc", cyc, 7); chk("lw0_rd_n", rd_n, 3); chk("lw0_alu", alu_out, 4); chk("lw0_pc", pc, 22);
    run(12'h203, 0, 0, 5'd0, cyc);
    chk("r0_zero", st_dout, 0);
    run(12'h041, 0, 1, 5'h13, cyc);
    chk("lw2_cyc", cyc, 6);
    run(12'h240, 0, 0, 5'd0, cyc);
    chk("r2_load", st_dout, 5'h13); chk("r2_addr", st_alu, 0); chk("r2_pc", pc, 28);

    // opcode 7
    run(12'hE00, 0, 0, 5'd0, cyc);
`ifdef VSA_HALT_EN
    chk("halt_cyc", cyc, 3); chk("halt_state", state, 5);
    chk("halt_flag", halted, 1); chk("halt_inst_req", inst_req, 0);
    repeat (3) @(negedge clock);
    chk("halt_pc", pc, 28); chk("halt_stay", state, 5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
`else
    chk("nop7_cyc", cyc, 5); chk("nop7_pc", pc, 30); chk("nop7_halted", halted, 0);
    run(12'hC00, 0, 0, 5'd0, cyc);
    chk("nop_wrap_pc", pc, 0);
`endif
    run(12'h825, 0, 0, 5'd0, cyc);
    chk("pre_rst_pc", pc, 2);

    // reset in the middle of a stalled store
    instruction = 12'h263; inst_valid = 1'b1; mem_ready = 1'b0;
    k = 0;
    while (state != 3'd3 && k < 10) begin @(negedge clock); k++; end
    chk("mid_wr", wr, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", wr, 0); chk("mid_rst_rd", rd, 0);
    chk("mid_rst_state", state, 0); chk("mid_rst_pc", pc, 0);
    chk("mid_rst_alu", alu_out, 0); chk("mid_rst_dout", dataout, 0);
    chk("mid_rst_req", inst_req, 1); chk("mid_rst_halted", halted, 0);
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b1;
    chk("rel_pc", pc, 0);
    run(12'h263, 0, 0, 5'd0, cyc);
    chk("rel_r3_clr", st_dout, 0); chk("rel_addr", st_alu, 3); chk("rel_pc2", pc, 2);
    run(12'h223, 0, 0, 5'd0, cyc);
    chk("rel_r1_clr", st_dout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
